// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution controller and its
// in-flight prediction queue.
package branch_pkg;

  localparam int PCSIZE = 16;

  localparam logic [2:0] BR_NONE = 3'b000;

  typedef struct packed {
    logic [PCSIZE-1:0] pc;
    logic              taken;
    logic [PCSIZE-1:0] target;
  } pred_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_RECOVER
  } ctrl_state_t;

endpackage

// File: rtl/branch_fifo.sv
// In-order queue of predicted branches awaiting resolution; clear discards
// every entry and wins over a concurrent push or pop.
module branch_fifo
  import branch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = pred_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  entry_t                 wdata,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  entry_t        mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign rdata   = mem[head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Matches execute-side branch resolutions against queued fetch predictions,
// issues one registered training write, and flushes/redirects on mispredicts.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int PCSIZE       = branch_pkg::PCSIZE,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pred_valid,
  output logic                   pred_ready,
  input  logic [PCSIZE-1:0]      pred_pc,
  input  logic                   pred_taken,
  input  logic [PCSIZE-1:0]      pred_target,
  input  logic                   res_valid,
  input  logic [2:0]             res_branch,
  input  logic                   res_taken,
  input  logic [PCSIZE-1:0]      res_target,
  output logic [2:0]             upd_branch,
  output logic [PCSIZE-1:0]      upd_pc,
  output logic                   upd_taken,
  output logic [PCSIZE-1:0]      upd_target,
  output logic                   flush,
  output logic [PCSIZE-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_underflow
);

  typedef struct packed {
    logic [PCSIZE-1:0] pc;
    logic              taken;
    logic [PCSIZE-1:0] target;
  } ctrl_entry_t;

  ctrl_state_t state_q, state_d;
  logic [3:0]  rcnt_q, rcnt_d;

  ctrl_entry_t head;
  ctrl_entry_t wentry;
  logic        full;
  logic        empty;
  logic        resolve;
  logic        mispredict;
  logic        push;
  logic        underflow;

  assign resolve    = res_valid && !empty && (res_branch != BR_NONE);
  assign mispredict = resolve &&
                      ((head.taken != res_taken) ||
                       (res_taken && (head.target != res_target)));
  assign underflow  = res_valid && empty;

  // No bypass: a pop in the same cycle never frees room for a push.
  assign pred_ready = (state_q == ST_RUN) && !full;
  assign push       = pred_valid && pred_ready && !mispredict;

  assign wentry.pc     = pred_pc;
  assign wentry.taken  = pred_taken;
  assign wentry.target = pred_target;

  branch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (ctrl_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (resolve),
    .clear (mispredict),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // The recovery counter leaves RECOVER on the step that takes it to zero,
  // so fetch sees exactly FLUSH_CYCLES cycles of pred_ready low.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d = ST_RECOVER;
          rcnt_d  = 4'(FLUSH_CYCLES);
        end
      end
      ST_RECOVER: begin
        if (rcnt_q <= 4'd1) begin
          state_d = ST_RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        rcnt_d  = '0;
      end
    endcase
  end

  // Training fields other than upd_branch hold between updates; upd_branch
  // alone qualifies the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_branch    <= BR_NONE;
      upd_pc        <= '0;
      upd_taken     <= 1'b0;
      upd_target    <= '0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      err_underflow <= 1'b0;
    end else begin
      upd_branch <= resolve ? res_branch : BR_NONE;
      if (resolve) begin
        upd_pc     <= head.pc;
        upd_taken  <= res_taken;
        upd_target <= res_target;
      end
      flush <= mispredict;
      if (mispredict)
        redirect_pc <= res_taken ? res_target : head.pc + PCSIZE'(4);
      if (underflow)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios with literal expectations
// followed by random traffic checked every cycle against a queue-based model.
module tb_branch_resolve_ctrl;

  localparam int PCSIZE       = 16;
  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic        pred_ready;
  logic [15:0] pred_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        res_valid;
  logic [2:0]  res_branch;
  logic        res_taken;
  logic [15:0] res_target;
  logic [2:0]  upd_branch;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        flush;
  logic [15:0] redirect_pc;
  logic [2:0]  count;
  logic        err_underflow;

  branch_resolve_ctrl #(
    .PCSIZE       (PCSIZE),
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_valid    (pred_valid),
    .pred_ready    (pred_ready),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .res_valid     (res_valid),
    .res_branch    (res_branch),
    .res_taken     (res_taken),
    .res_target    (res_target),
    .upd_branch    (upd_branch),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .count         (count),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        taken;
    logic [15:0] tgt;
  } ent_t;

  ent_t        pq[$];
  int          block_left;
  logic [2:0]  e_upd_branch;
  logic [15:0] e_upd_pc;
  logic        e_upd_taken;
  logic [15:0] e_upd_target;
  logic        e_flush;
  logic [15:0] e_redirect;
  logic        e_err;

  int checks;
  int errors;
  bit check_en;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit model_ready();
    return (block_left == 0) && (pq.size() < DEPTH);
  endfunction

  task automatic resetModel();
    pq.delete();
    block_left   = 0;
    e_upd_branch = 3'd0;
    e_upd_pc     = 16'd0;
    e_upd_taken  = 1'b0;
    e_upd_target = 16'd0;
    e_flush      = 1'b0;
    e_redirect   = 16'd0;
    e_err        = 1'b0;
  endtask

  // One clock of the rules: what was sampled at the edge becomes the
  // expected post-edge view.
  task automatic modelStep(input logic pv, input logic [15:0] ppc, input logic pt,
                           input logic [15:0] ptg, input logic rv, input logic [2:0] rb,
                           input logic rt, input logic [15:0] rtg);
    bit   ready;
    bit   res;
    bit   mis;
    ent_t h;
    ent_t n;
    ready = model_ready();
    res   = rv && (pq.size() > 0) && (rb != 3'd0);
    mis   = 1'b0;
    if (res) begin
      h   = pq[0];
      mis = (h.taken != rt) || (rt && (h.tgt != rtg));
      e_upd_pc     = h.pc;
      e_upd_taken  = rt;
      e_upd_target = rtg;
    end
    e_upd_branch = res ? rb : 3'd0;
    e_flush      = mis;
    if (mis) e_redirect = rt ? rtg : 16'(h.pc + 16'd4);
    if (rv && pq.size() == 0) e_err = 1'b1;
    if (mis) begin
      pq.delete();
      block_left = FLUSH_CYCLES;
    end else begin
      if (res) void'(pq.pop_front());
      if (pv && ready) begin
        n.pc = ppc; n.taken = pt; n.tgt = ptg;
        pq.push_back(n);
      end
      if (block_left > 0) block_left--;
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [15:0] ppc, input logic pt,
                               input logic [15:0] ptg, input logic rv, input logic [2:0] rb,
                               input logic rt, input logic [15:0] rtg);
    pred_valid  = pv;
    pred_pc     = ppc;
    pred_taken  = pt;
    pred_target = ptg;
    res_valid   = rv;
    res_branch  = rb;
    res_taken   = rt;
    res_target  = rtg;
    @(posedge clk);
    #1;
    modelStep(pv, ppc, pt, ptg, rv, rb, rt, rtg);
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h0);
  endtask

  task automatic push(input logic [15:0] pc, input logic t, input logic [15:0] tgt);
    applyStimulus(1'b1, pc, t, tgt, 1'b0, 3'd0, 1'b0, 16'h0);
  endtask

  task automatic resolveBr(input logic [2:0] rb, input logic t, input logic [15:0] tgt);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, rb, t, tgt);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    resetModel();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (check_en && !rst) begin
      checkOutput("m_pred_ready", pred_ready, model_ready());
      checkOutput("m_count", count, pq.size());
      checkOutput("m_upd_branch", upd_branch, e_upd_branch);
      checkOutput("m_flush", flush, e_flush);
      checkOutput("m_redirect_pc", redirect_pc, e_redirect);
      checkOutput("m_err_underflow", err_underflow, e_err);
      if (e_upd_branch != 3'd0) begin
        checkOutput("m_upd_pc", upd_pc, e_upd_pc);
        checkOutput("m_upd_taken", upd_taken, e_upd_taken);
        checkOutput("m_upd_target", upd_target, e_upd_target);
      end
    end
  end

  initial begin
    logic        pv, pt, rv, rt;
    logic [15:0] ppc, ptg, rtg;
    logic [2:0]  rb;

    checks      = 0;
    errors      = 0;
    check_en    = 1'b0;
    rst         = 1'b1;
    pred_valid  = 1'b0;
    pred_pc     = 16'h0;
    pred_taken  = 1'b0;
    pred_target = 16'h0;
    res_valid   = 1'b0;
    res_branch  = 3'd0;
    res_taken   = 1'b0;
    res_target  = 16'h0;
    resetModel();
    #22;
    rst = 1'b0;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_ready", pred_ready, 1);
    checkOutput("rst_upd_branch", upd_branch, 0);
    checkOutput("rst_flush", flush, 0);
    checkOutput("rst_redirect", redirect_pc, 0);
    check_en = 1'b1;

    // Correctly predicted taken branch trains without flushing.
    push(16'h0010, 1'b1, 16'h0040);
    resolveBr(3'b001, 1'b1, 16'h0040);
    checkOutput("t1_upd_branch", upd_branch, 1);
    checkOutput("t1_upd_pc", upd_pc, 16'h0010);
    checkOutput("t1_upd_taken", upd_taken, 1);
    checkOutput("t1_flush", flush, 0);
    checkOutput("t1_count", count, 0);

    // Direction mispredict discards the younger entry and blocks fetch.
    push(16'h0020, 1'b0, 16'h0000);
    push(16'h0030, 1'b0, 16'h0000);
    resolveBr(3'b001, 1'b1, 16'h0100);
    checkOutput("t2_flush", flush, 1);
    checkOutput("t2_redirect", redirect_pc, 16'h0100);
    checkOutput("t2_count", count, 0);
    checkOutput("t2_ready_c0", pred_ready, 0);
    idle();
    checkOutput("t2_ready_c1", pred_ready, 0);
    checkOutput("t2_flush_off", flush, 0);
    idle();
    checkOutput("t2_ready_c2", pred_ready, 1);

    // Predicted taken, actually not taken: fall through to pc+4.
    push(16'h0050, 1'b1, 16'h0080);
    resolveBr(3'b010, 1'b0, 16'h0000);
    checkOutput("t3_flush", flush, 1);
    checkOutput("t3_redirect", redirect_pc, 16'h0054);
    checkOutput("t3_upd_taken", upd_taken, 0);
    idle();
    idle();

    // Full queue refuses a push even while an entry pops.
    for (int i = 0; i < 4; i++) push(16'(16'h0100 + i * 4), 1'b0, 16'h0000);
    checkOutput("t4_count_full", count, 4);
    checkOutput("t4_ready_full", pred_ready, 0);
    applyStimulus(1'b1, 16'h0200, 1'b0, 16'h0, 1'b1, 3'b001, 1'b0, 16'h0);
    checkOutput("t4_count_after", count, 3);
    checkOutput("t4_upd_pc", upd_pc, 16'h0100);
    for (int i = 0; i < 3; i++) resolveBr(3'b001, 1'b0, 16'h0000);

    // Resolve against an empty queue is flagged and sticky.
    resolveBr(3'b001, 1'b1, 16'h0300);
    checkOutput("t5_err", err_underflow, 1);
    checkOutput("t5_upd_branch", upd_branch, 0);
    checkOutput("t5_flush", flush, 0);
    idle();
    checkOutput("t5_err_sticky", err_underflow, 1);
    doReset();
    checkOutput("t5_err_cleared", err_underflow, 0);

    // Random traffic; branch type 0 is only offered while the queue is non-empty.
    for (int i = 0; i < 2000; i++) begin
      pv  = ($urandom_range(0, 99) < 55);
      ppc = 16'($urandom);
      pt  = 1'($urandom_range(0, 1));
      ptg = 16'(16'h0100 + 4 * $urandom_range(0, 3));
      rv  = ($urandom_range(0, 99) < 45);
      if (pq.size() > 0 && $urandom_range(0, 99) < 65) begin
        rt  = pq[0].taken;
        rtg = pq[0].tgt;
      end else begin
        rt  = 1'($urandom_range(0, 1));
        rtg = 16'(16'h0100 + 4 * $urandom_range(0, 3));
      end
      rb = (pq.size() > 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 7));
      applyStimulus(pv, ppc, pt, ptg, rv, rb, rt, rtg);
    end

    // Target mismatch flush, then reset lands inside the flush cycle.
    doReset();
    push(16'h0060, 1'b1, 16'h0200);
    resolveBr(3'b011, 1'b1, 16'h0204);
    checkOutput("t6_flush", flush, 1);
    checkOutput("t6_redirect", redirect_pc, 16'h0204);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_flush", flush, 0);
    checkOutput("t6_rst_redirect", redirect_pc, 0);
    checkOutput("t6_rst_upd_branch", upd_branch, 0);
    checkOutput("t6_rst_upd_pc", upd_pc, 0);
    checkOutput("t6_rst_upd_taken", upd_taken, 0);
    checkOutput("t6_rst_upd_target", upd_target, 0);
    checkOutput("t6_rst_count", count, 0);
    checkOutput("t6_rst_err", err_underflow, 0);
    resetModel();
    @(negedge clk);
    #2;
    rst = 1'b0;
    idle();
    idle();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the branch predictor and BTB. It tracks in-flight predicted branches from fetch in a small in-order queue.
- When execute resolves a branch, the block compares the actual outcome against the prediction. It then issues a single registered training write to the predictor/BTB update ports.
- On a mispredict it raises a flush and a redirect PC, and blocks new fetch predictions for a fixed recovery window.
- It sits between fetch (prediction side) and execute (resolution side).

Parameters:
PCSIZE, 16, width of PCs and targets
DEPTH, 4, in-flight branch queue entries (power of 2, 2..16)
FLUSH_CYCLES, 2, cycles pred_ready held low after a flush (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
pred_valid  in  1  fetch pushes a predicted branch
pred_ready  out  1  queue can accept (combinational from count/state)
pred_pc  in  PCSIZE  PC of predicted branch
pred_taken  in  1  predicted direction
pred_target  in  PCSIZE  predicted target (BTB addrout)
res_valid  in  1  execute resolves the oldest branch
res_branch  in  3  branch type; nonzero = real branch
res_taken  in  1  actual direction
res_target  in  PCSIZE  actual target
upd_branch  out  3  registered copy of res_branch, 0 when no update (drives predictor/BTB branch input)
upd_pc  out  PCSIZE  PC to train (PCupdate)
upd_taken  out  1  outcome to train
upd_target  out  PCSIZE  target to train
flush  out  1  one-cycle mispredict pulse
redirect_pc  out  PCSIZE  corrected fetch PC, valid with flush
count  out  $clog2(DEPTH)+1  queue occupancy
err_underflow  out  1  sticky: resolve seen with empty queue

Behaviour:
- Reset (async assert, sync deassert use) sets the following: count=0, head/tail=0, state=RUN, upd_branch=0, upd_pc=0, upd_taken=0, upd_target=0, flush=0, redirect_pc=0, err_underflow=0.
- States:
  - RUN: pred_ready = (count<DEPTH).
  - RECOVER: pred_ready=0; a down-counter loaded with FLUSH_CYCLES; returns to RUN when it reaches 0.
- Enqueue: on pred_valid && pred_ready, write {pred_pc, pred_taken, pred_target} at tail; tail wraps modulo DEPTH.
- Resolve: on res_valid && count>0 && res_branch!=0, pop head.
  - Mispredict = (head.taken != res_taken) || (res_taken && head.target != res_target).
- Latency: exactly 1 cycle from the resolve edge to the outputs. Next cycle: upd_branch=res_branch, upd_pc=head.pc, upd_taken=res_taken, upd_target=res_target for one cycle; otherwise upd_branch=0.
- Mispredict, same output cycle: flush=1 and redirect_pc = res_taken ? res_target : head.pc+4 (mod 2^PCSIZE). Also in that cycle:
  - all remaining entries are discarded (count=0, head=tail);
  - state moves to RECOVER;
  - any enqueue in the resolving cycle is dropped.
- Correct prediction: flush=0; redirect_pc holds its previous value.
- Simultaneous enqueue+resolve (correct prediction) in RUN: both occur and count is unchanged. When full, pred_ready=0 even if a pop is concurrent; no same-cycle bypass.
- res_valid with res_branch==0: ignored, nothing popped.
- res_valid with count==0: no pop, no update, err_underflow set (cleared only by rst).
- A resolve during RECOVER with an empty queue sets err_underflow.
- rst mid-operation: all state cleared immediately, including a pending flush pulse.

Decomposition:
- Shared package branch_pkg: PCSIZE constant, pred_entry_t struct {pc, taken, target}, BR_NONE=3'b000 constant.
- Sub-module branch_fifo (param DEPTH, entry type; push/pop/clear, count, full/empty); controller FSM and compare logic stay in branch_resolve_ctrl.

Test Plan:
- Reset, push pc=0x0010 taken=1 tgt=0x0040, resolve taken=1 tgt=0x0040, branch=3'b001 -> next cycle upd_branch=1, upd_pc=0x0010, upd_taken=1, flush=0, count=0.
- Push pc=0x0020 taken=0, push pc=0x0030; resolve first with taken=1 tgt=0x0100 -> flush=1, redirect_pc=0x0100, count=0, pred_ready=0 for 2 cycles then 1.
- Push pc=0x0050 taken=1 tgt=0x0080, resolve taken=0 -> flush=1, redirect_pc=0x0054, upd_taken=0.
- Push 4 entries -> pred_ready=0, count=4; push+resolve same cycle -> push ignored, count=3.
- Resolve with empty queue -> err_underflow=1 sticky, upd_branch=0, no flush; rst clears it.
- Push tgt mismatch (pred tgt 0x0200, actual 0x0204, both taken) -> flush=1, redirect_pc=0x0204; assert rst during that flush cycle -> all outputs 0 immediately.
